// File: rtl/add_result_accumulator.sv
// Sums BATCH {cout,sum} beats from the carry-select adder, counts carry-outs,
// and offers the batch total downstream on a valid/ready handshake.
module add_result_accumulator #(
  parameter  int N     = 8,
  parameter  int BATCH = 4,
  localparam int ACC_W = N + 1 + $clog2(BATCH),
  localparam int CNT_W = $clog2(BATCH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     sum,
  input  logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] carry_cnt,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             dbg_state_o
);

  // Handshakes: a beat moves when in_valid & in_ready at a rising edge;
  // a result moves when out_valid & out_ready at a rising edge. Both ready/valid
  // outputs depend only on registered state, never on the partner's signals.
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] carry_q, carry_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [ACC_W-1:0] beat_ext;

  assign beat_ext = {{(ACC_W - N - 1){1'b0}}, cout, sum};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      carry_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    beat_d  = beat_q;
    if (clear) begin
      // Abort drops any beat or result that would otherwise move this edge.
      state_d = ACCUM;
      acc_d   = '0;
      carry_d = '0;
      beat_d  = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            acc_d   = acc_q + beat_ext;
            carry_d = carry_q + CNT_W'(cout);
            beat_d  = beat_q + CNT_W'(1);
            if (beat_q == CNT_W'(BATCH - 1)) state_d = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            carry_d = '0;
            beat_d  = '0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  assign in_ready    = (state_q == ACCUM);
  assign out_valid   = (state_q == HOLD);
  assign acc         = acc_q;
  assign carry_cnt   = carry_q;
  assign beat_cnt    = beat_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_add_result_accumulator.sv
// Directed bench for add_result_accumulator (N=8, BATCH=4) with hand-computed totals.
module tb_add_result_accumulator;

  localparam int N     = 8;
  localparam int BATCH = 4;
  localparam int ACC_W = N + 1 + $clog2(BATCH);
  localparam int CNT_W = $clog2(BATCH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     sum;
  logic             cout;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] carry_cnt;
  logic [CNT_W-1:0] beat_cnt;
  logic             dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;

  add_result_accumulator #(.N(N), .BATCH(BATCH)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum        (sum),
    .cout       (cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .acc        (acc),
    .carry_cnt  (carry_cnt),
    .beat_cnt   (beat_cnt),
    .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drivers: inputs change at negedge, outputs sampled 1ns after posedge.
  task automatic drive_beat(input logic c, input logic [N-1:0] s);
    @(negedge clk);
    in_valid = 1'b1;
    cout     = c;
    sum      = s;
    check("in_ready_before_beat", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic ov, input logic ir,
                               input int a, input int cc, input int bc);
    check({tag, "_out_valid"}, out_valid, ov);
    check({tag, "_in_ready"},  in_ready,  ir);
    check({tag, "_acc"},       acc,       a);
    check({tag, "_carry_cnt"}, carry_cnt, cc);
    check({tag, "_beat_cnt"},  beat_cnt,  bc);
  endtask

  task automatic handshake_cycle;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; sum = '0; cout = 1'b0; out_ready = 1'b0;
    #2;
    check_outputs("reset", 0, 1, 0, 0, 0);
    check("reset_state", dbg_state_o, 0);
    #10 rst = 1'b0;

    // Basic batch: 10 + 20 + 261 + 511 = 802, two carries
    drive_beat(1'b0, 8'h0A);
    check("basic_partial_acc", acc, 10);
    drive_beat(1'b0, 8'h14);
    drive_beat(1'b1, 8'h05);
    check("basic_pre_last_valid", out_valid, 0);
    drive_beat(1'b1, 8'hFF);
    check_outputs("basic", 1, 0, 802, 2, 4);
    check("basic_state", dbg_state_o, 1);

    // Backpressure: input beats offered during HOLD must be ignored
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      cout     = i[0];
      sum      = 8'(8'h33 + i);
      @(posedge clk);
      #1;
      check_outputs("backpressure", 1, 0, 802, 2, 4);
    end
    // Handshake with in_valid still high: no beat may be taken on that edge
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_outputs("handshake", 0, 1, 0, 0, 0);
    in_valid = 1'b0;

    // Max values: 4 * 511 = 2044 fits in 11 bits
    for (int i = 0; i < BATCH; i++) drive_beat(1'b1, 8'hFF);
    check_outputs("max", 1, 0, 2044, 4, 4);
    handshake_cycle();
    check_outputs("max_after_hs", 0, 1, 0, 0, 0);

    // clear mid-batch drops the concurrent beat
    drive_beat(1'b0, 8'd10);
    drive_beat(1'b0, 8'd20);
    check("clear_pre_acc", acc, 30);
    check("clear_pre_beats", beat_cnt, 2);
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; cout = 1'b1; sum = 8'd5;
    @(posedge clk);
    #1;
    clear = 1'b0; in_valid = 1'b0;
    check_outputs("clear_mid", 0, 1, 0, 0, 0);
    for (int i = 0; i < BATCH; i++) drive_beat(1'b0, 8'd1);
    check_outputs("after_clear", 1, 0, 4, 0, 4);

    // clear beats a simultaneous output handshake
    @(negedge clk);
    clear = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0; out_ready = 1'b0;
    check_outputs("clear_hold", 0, 1, 0, 0, 0);

    // Async reset in HOLD: 4 * 384 = 1536
    for (int i = 0; i < BATCH; i++) drive_beat(1'b1, 8'h80);
    check_outputs("pre_rst", 1, 0, 1536, 4, 4);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 0, 1, 0, 0, 0);
    #4 rst = 1'b0;

    // Normal operation resumes after reset
    drive_beat(1'b1, 8'h01);
    check("post_rst_acc", acc, 257);
    check("post_rst_carry", carry_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
